mem_allocator: RTL and testbench

- Arbitrates the single byte-wide RAM port between three requesters: instruction fetch reads, LSBuffer loads and LSBuffer committed stores.
- Serialises each 1/2/4-byte transaction into per-byte RAM cycles and reassembles read data.
- Sits between the fetch unit, the LSBuffer and the top-level RAM/IO pins.
- Returns a one-cycle grant pulse on acceptance and a one-cycle done pulse on completion.

---
 rtl/mem_allocator_pkg.sv | 14 +
 rtl/mem_alloc_arbiter.sv | 17 +
 rtl/mem_allocator.sv | 157 +++++++++++++++
 tb/tb_mem_allocator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_allocator_pkg.sv
// mem_allocator_pkg: shared widths, state/source encodings and the IO window select
// for the byte-serial RAM port allocator.
package mem_allocator_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic [1:0] {SRC_IF, SRC_LSB_R, SRC_LSB_W} src_t;

    function automatic logic [7:0] byte_of(input logic [WORD_WIDTH-1:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/mem_alloc_arbiter.sv
// mem_alloc_arbiter: fixed-priority picker (store > load > fetch); a flush masks the
// read requesters but never the committed store.
module mem_alloc_arbiter
    import mem_allocator_pkg::*;
(
    input  logic w_req,
    input  logic r_req,
    input  logic f_req,
    input  logic clear,
    output logic valid,
    output src_t src
);
    always_comb begin
        valid = w_req | (!clear & (r_req | f_req));
        src   = w_req ? SRC_LSB_W : r_req ? SRC_LSB_R : SRC_IF;
    end
endmodule

// File: rtl/mem_allocator.sv
// mem_allocator: arbitrates fetch reads, loads and stores onto the single byte-wide RAM
// port, serialising each 1/2/4-byte transaction and reassembling read data.
module mem_allocator
    import mem_allocator_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int WordWidth = WORD_WIDTH,
    parameter logic [1:0] IoSel = IO_SEL
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_branch_in,
    input  logic                 io_buffer_full_in,
    input  logic [7:0]           mem_din_in,
    output logic [7:0]           mem_dout_out,
    output logic [AddrWidth-1:0] mem_a_out,
    output logic                 mem_wr_out,
    input  logic                 if_r_en_in,
    input  logic [1:0]           if_r_offset_in,
    input  logic [AddrWidth-1:0] if_r_a_in,
    output logic                 alloc_to_if_r_gr_out,
    output logic                 alloc_to_if_r_en_out,
    output logic [WordWidth-1:0] if_d_out,
    input  logic                 lsb_to_alloc_r_en_in,
    input  logic [1:0]           lsb_r_offset_in,
    input  logic [AddrWidth-1:0] lsb_r_a_in,
    output logic                 alloc_to_lsb_r_gr_out,
    output logic                 alloc_to_lsb_r_en_out,
    output logic [WordWidth-1:0] lsb_d_out,
    input  logic                 lsb_to_alloc_w_en_in,
    input  logic [1:0]           lsb_w_offset_in,
    input  logic [AddrWidth-1:0] lsb_w_a_in,
    input  logic [WordWidth-1:0] lsb_d_in,
    output logic                 alloc_to_lsb_w_gr_out,
    output logic                 alloc_to_lsb_w_en_out
);
    state_t                 state;
    src_t                   src;
    src_t                   pick_src;
    logic                   pick;
    logic [AddrWidth-1:0]   addr;
    logic [AddrWidth-1:0]   sel_a;
    logic [AddrWidth-1:0]   cur_a;
    logic [AddrWidth-1:0]   nxt_a;
    logic [WordWidth-1:0]   wdata;
    logic [WordWidth-1:0]   rbuf;
    logic [WordWidth-1:0]   rd_word;
    logic [1:0]             sel_off;
    logic [2:0]             cnt;
    logic [2:0]             len;
    logic                   last;
    logic                   io_stall;

    mem_alloc_arbiter u_arb (
        .w_req(lsb_to_alloc_w_en_in),
        .r_req(lsb_to_alloc_r_en_in),
        .f_req(if_r_en_in),
        .clear(clear_branch_in),
        .valid(pick),
        .src  (pick_src)
    );

    always_comb begin
        sel_a    = pick_src == SRC_LSB_W ? lsb_w_a_in : pick_src == SRC_LSB_R ? lsb_r_a_in : if_r_a_in;
        sel_off  = pick_src == SRC_LSB_W ? lsb_w_offset_in : pick_src == SRC_LSB_R ? lsb_r_offset_in : if_r_offset_in;
        cur_a    = addr + AddrWidth'(cnt);
        nxt_a    = addr + AddrWidth'(cnt + 3'd1);
        last     = cnt + 3'd1 == len;
        rd_word  = rbuf | (WordWidth'(mem_din_in) << {cnt[1:0], 3'b000});
        io_stall = addr[17:16] == IoSel && io_buffer_full_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                 <= IDLE;
            src                   <= SRC_IF;
            addr                  <= '0;
            wdata                 <= '0;
            rbuf                  <= '0;
            cnt                   <= '0;
            len                   <= '0;
            mem_a_out             <= '0;
            mem_dout_out          <= '0;
            mem_wr_out            <= 1'b0;
            alloc_to_if_r_gr_out  <= 1'b0;
            alloc_to_if_r_en_out  <= 1'b0;
            alloc_to_lsb_r_gr_out <= 1'b0;
            alloc_to_lsb_r_en_out <= 1'b0;
            alloc_to_lsb_w_gr_out <= 1'b0;
            alloc_to_lsb_w_en_out <= 1'b0;
            if_d_out              <= '0;
            lsb_d_out             <= '0;
        end else if (rdy_in) begin
            alloc_to_if_r_gr_out  <= 1'b0;
            alloc_to_if_r_en_out  <= 1'b0;
            alloc_to_lsb_r_gr_out <= 1'b0;
            alloc_to_lsb_r_en_out <= 1'b0;
            alloc_to_lsb_w_gr_out <= 1'b0;
            alloc_to_lsb_w_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr_out <= 1'b0;
                    mem_a_out  <= '0;
                    if (pick) begin
                        src                   <= pick_src;
                        addr                  <= sel_a;
                        len                   <= {1'b0, sel_off} + 3'd1;
                        wdata                 <= lsb_d_in;
                        rbuf                  <= '0;
                        cnt                   <= '0;
                        state                 <= pick_src == SRC_LSB_W ? WRITE : READ;
                        mem_a_out             <= pick_src == SRC_LSB_W ? '0 : sel_a;
                        alloc_to_if_r_gr_out  <= pick_src == SRC_IF;
                        alloc_to_lsb_r_gr_out <= pick_src == SRC_LSB_R;
                        alloc_to_lsb_w_gr_out <= pick_src == SRC_LSB_W;
                    end
                end
                READ: begin
                    // A flush kills the read outright; the requester re-fetches later.
                    if (clear_branch_in) begin
                        state     <= IDLE;
                        mem_a_out <= '0;
                    end else if (last) begin
                        state     <= IDLE;
                        mem_a_out <= '0;
                        if (src == SRC_IF) begin
                            if_d_out             <= rd_word;
                            alloc_to_if_r_en_out <= 1'b1;
                        end else begin
                            lsb_d_out             <= rd_word;
                            alloc_to_lsb_r_en_out <= 1'b1;
                        end
                    end else begin
                        rbuf      <= rd_word;
                        cnt       <= cnt + 3'd1;
                        mem_a_out <= nxt_a;
                    end
                end
                WRITE: begin
                    if (cnt == len) begin
                        state                 <= IDLE;
                        mem_wr_out            <= 1'b0;
                        mem_a_out             <= '0;
                        alloc_to_lsb_w_en_out <= 1'b1;
                    end else begin
                        mem_a_out    <= cur_a;
                        mem_dout_out <= byte_of(wdata, cnt[1:0]);
                        mem_wr_out   <= !io_stall;
                        if (!io_stall) cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_allocator.sv
// tb_mem_allocator: directed and randomized requesters against a transaction-level model
// of the allocator, with a byte RAM answering combinationally from mem_a_out.
module tb_mem_allocator;
    logic        clk = 0;
    logic        rst;
    logic        rdy = 1, clr = 0, io_full = 0;
    logic [7:0]  din, dout;
    logic [31:0] ma;
    logic        wr;
    logic        f_en = 0, r_en = 0, w_en = 0;
    logic [1:0]  f_off = 0, r_off = 0, w_off = 0;
    logic [31:0] f_a = 0, r_a = 0, w_a = 0, w_d = 0;
    logic        f_gr, f_done, l_gr, l_done, w_gr, w_done;
    logic [31:0] f_d, l_d;
    logic [7:0]  ram [0:65535];
    int          errors = 0, checks = 0;

    mem_allocator dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_branch_in(clr),
        .io_buffer_full_in(io_full), .mem_din_in(din), .mem_dout_out(dout),
        .mem_a_out(ma), .mem_wr_out(wr),
        .if_r_en_in(f_en), .if_r_offset_in(f_off), .if_r_a_in(f_a),
        .alloc_to_if_r_gr_out(f_gr), .alloc_to_if_r_en_out(f_done), .if_d_out(f_d),
        .lsb_to_alloc_r_en_in(r_en), .lsb_r_offset_in(r_off), .lsb_r_a_in(r_a),
        .alloc_to_lsb_r_gr_out(l_gr), .alloc_to_lsb_r_en_out(l_done), .lsb_d_out(l_d),
        .lsb_to_alloc_w_en_in(w_en), .lsb_w_offset_in(w_off), .lsb_w_a_in(w_a),
        .lsb_d_in(w_d), .alloc_to_lsb_w_gr_out(w_gr), .alloc_to_lsb_w_en_out(w_done)
    );

    always #5 clk = ~clk;
    assign din = ram[ma[15:0]];
    always @(posedge clk) if (wr) ram[ma[15:0]] <= dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ram[16'(a + 32'(i))];
        return v;
    endfunction

    // Transaction-level model: one in-flight transaction, tracked by elapsed cycles and bytes written.
    int          m_st = 0, m_src = 0, m_n = 0, m_t = 0, m_w = 0;
    logic [31:0] m_a = 0, m_d = 0;
    logic [31:0] e_a = 0, e_if_d = 0, e_lsb_d = 0;
    logic [7:0]  e_dout = 0;
    logic        e_wr = 0;
    logic [2:0]  e_gr = 0, e_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; e_a = 0; e_wr = 0; e_gr = 0; e_done = 0; e_if_d = 0; e_lsb_d = 0;
        end else if (rdy) begin
            e_gr = 0;
            e_done = 0;
            if (m_st == 0) begin
                if (w_en) begin m_st = 2; m_src = 2; m_a = w_a; m_n = int'(w_off) + 1; m_d = w_d; end
                else if (!clr && r_en) begin m_st = 1; m_src = 1; m_a = r_a; m_n = int'(r_off) + 1; end
                else if (!clr && f_en) begin m_st = 1; m_src = 0; m_a = f_a; m_n = int'(f_off) + 1; end
                if (m_st != 0) begin
                    e_gr[m_src] = 1; m_t = 0; m_w = 0;
                    e_a = (m_st == 1) ? m_a : 0;
                end
            end else if (m_st == 1) begin
                m_t++;
                if (clr) begin m_st = 0; e_a = 0; end
                else if (m_t == m_n) begin
                    e_done[m_src] = 1;
                    if (m_src == 0) e_if_d = ram_word(m_a, m_n); else e_lsb_d = ram_word(m_a, m_n);
                    m_st = 0; e_a = 0;
                end else e_a = m_a + 32'(m_t);
            end else begin
                if (m_w == m_n) begin
                    e_done[2] = 1; e_wr = 0; e_a = 0; m_st = 0;
                end else begin
                    e_a = m_a + 32'(m_w);
                    e_dout = m_d[8*m_w +: 8];
                    if (m_a[17:16] == 2'b11 && io_full) e_wr = 0;
                    else begin e_wr = 1; m_w++; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_a", ma, e_a);
            chk("mem_wr", 32'(wr), 32'(e_wr));
            if (e_wr) chk("mem_dout", 32'(dout), 32'(e_dout));
            chk("grants", 32'({w_gr, l_gr, f_gr}), 32'(e_gr));
            chk("dones", 32'({w_done, l_done, f_done}), 32'(e_done));
            chk("if_d", f_d, e_if_d);
            chk("lsb_d", l_d, e_lsb_d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (f_gr) f_en = 0;
        if (l_gr) r_en = 0;
        if (w_gr) w_en = 0;
    endtask

    // sel: 0..2 grants (fetch, load, store), 3..5 dones
    task automatic wait_pulse(input int sel, input int limit);
        logic [5:0] p;
        int n = 0;
        p = {w_done, l_done, f_done, w_gr, l_gr, f_gr};
        while (!p[sel] && n < limit) begin
            step();
            n++;
            p = {w_done, l_done, f_done, w_gr, l_gr, f_gr};
        end
        chk("wait_bound", 32'(p[sel]), 32'd1);
    endtask

    function automatic logic [31:0] rnd_a();
        case ($urandom_range(3))
            0: return 32'hFFFF_FFFC + 32'($urandom_range(3));
            1: return {14'($urandom), 2'b11, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int gw, gl, gf, dw, dl, df, seen;
        rst = 1;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h100] = 8'h11; ram[16'h101] = 8'h22; ram[16'h102] = 8'h33; ram[16'h103] = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_a", ma, 0);
        chk("rst_mem_wr", 32'(wr), 0);
        chk("rst_pulses", 32'({w_gr, l_gr, f_gr, w_done, l_done, f_done}), 0);
        chk("rst_data", f_d | l_d, 0);
        rst = 0;
        step();

        // load word
        r_en = 1; r_a = 32'h100; r_off = 3;
        step();
        chk("ld_gr", 32'(l_gr), 1);
        chk("ld_a0", ma, 32'h100);
        step(); chk("ld_a1", ma, 32'h101);
        step(); chk("ld_a2", ma, 32'h102);
        step(); chk("ld_a3", ma, 32'h103);
        step();
        chk("ld_done", 32'(l_done), 1);
        chk("ld_data", l_d, 32'h4433_2211);
        step();

        // store halfword
        w_en = 1; w_a = 32'h200; w_d = 32'hAABB_CCDD; w_off = 1;
        step(); chk("st_gr", 32'(w_gr), 1); chk("st_wr_idle", 32'(wr), 0);
        step(); chk("st_b0", {ma[15:0], dout, 7'b0, wr}, {16'h0200, 8'hDD, 8'h01});
        step(); chk("st_b1", {ma[15:0], dout, 7'b0, wr}, {16'h0201, 8'hCC, 8'h01});
        step(); chk("st_done", 32'({wr, w_done}), 32'b01);
        step();
        chk("st_ram", 32'({ram[16'h201], ram[16'h200]}), 32'hCCDD);

        // simultaneous requests
        f_en = 1; f_a = 32'h100; f_off = 3;
        r_en = 1; r_a = 32'h102; r_off = 0;
        w_en = 1; w_a = 32'h300; w_d = 32'h5A; w_off = 0;
        gw = -1; gl = -1; gf = -1; dw = -1; dl = -1; df = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (w_gr) gw = c; if (l_gr) gl = c; if (f_gr) gf = c;
            if (w_done) dw = c; if (l_done) dl = c; if (f_done) df = c;
        end
        chk("pri_order", 32'(gw >= 0 && gw < gl && gl < gf), 1);
        chk("pri_gap_st", 32'(dw >= 0 && dw < gl), 1);
        chk("pri_gap_ld", 32'(dl >= 0 && dl < gf), 1);
        chk("pri_if_done", 32'(df > gf), 1);
        chk("pri_ld_data", l_d, 32'h33);
        chk("pri_if_data", f_d, 32'h4433_2211);

        // IO stall
        w_en = 1; w_a = 32'h0003_0000; w_d = 32'h77; w_off = 0; io_full = 1;
        step(); chk("io_gr", 32'(w_gr), 1);
        for (int i = 0; i < 3; i++) begin step(); chk("io_stall_wr", 32'(wr), 0); end
        io_full = 0;
        step(); chk("io_write", {ma, 23'b0, wr, dout} == {32'h0003_0000, 23'b0, 1'b1, 8'h77} ? 32'd1 : 32'd0, 1);
        step(); chk("io_done", 32'({wr, w_done}), 32'b01);
        step();

        // flush during fetch
        f_en = 1; f_a = 32'h100; f_off = 3;
        step(); chk("cl_gr", 32'(f_gr), 1);
        step(); chk("cl_a1", ma, 32'h101);
        clr = 1; w_en = 1; w_a = 32'h500; w_d = 32'h99; w_off = 0;
        step();
        chk("cl_abort", 32'({f_done, w_gr}), 0);
        chk("cl_idle_a", ma, 0);
        clr = 0;
        step(); chk("cl_store_gr", 32'(w_gr), 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin step(); if (f_done) seen = 1; end
        chk("cl_no_done", 32'(seen), 0);

        // reset mid-write
        ram[16'h401] = 8'hEE;
        w_en = 1; w_a = 32'h400; w_d = 32'h1234_5678; w_off = 3;
        step(); chk("rs_gr", 32'(w_gr), 1);
        step(); step();
        chk("rs_writing", 32'(wr), 1);
        #2 rst = 1;
        #1;
        chk("rs_now", {wr, ma} == 33'd0 ? 32'd1 : 32'd0, 1);
        chk("rs_pulses", 32'({w_gr, l_gr, f_gr, w_done, l_done, f_done}), 0);
        chk("rs_data", f_d | l_d, 0);
        @(posedge clk); #1;
        chk("rs_hold", 32'({wr, w_done}), 0);
        rst = 0;
        step();
        r_en = 1; r_a = 32'h400; r_off = 1;
        wait_pulse(4, 20);
        chk("rs_load", l_d, 32'h0000_EE78);
        step();

        // address wrap
        ram[16'hFFFF] = 8'hA1; ram[16'h0000] = 8'hB2;
        r_en = 1; r_a = 32'hFFFF_FFFF; r_off = 1;
        step();
        step(); chk("wrap_a", ma, 0);
        wait_pulse(4, 10);
        chk("wrap_data", l_d, 32'h0000_B2A1);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            rdy = $urandom_range(9) != 0;
            clr = $urandom_range(19) == 0;
            io_full = $urandom_range(2) == 0;
            if (!f_en && !f_gr && $urandom_range(3) == 0) begin f_en = 1; f_a = rnd_a(); f_off = 2'($urandom); end
            if (!r_en && !l_gr && $urandom_range(3) == 0) begin r_en = 1; r_a = rnd_a(); r_off = 2'($urandom); end
            if (!w_en && !w_gr && $urandom_range(5) == 0) begin
                w_en = 1; w_a = rnd_a(); w_off = 2'($urandom); w_d = $urandom;
            end
        end
        rdy = 1; clr = 0; io_full = 0;
        repeat (60) step();
        chk("drained", 32'({f_en, r_en, w_en}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
